// File: rtl/aes_sub_bytes_ctrl_pkg.sv
// Shared constants and types for the masked SubBytes sequencer.
package aes_sub_bytes_ctrl_pkg;

  localparam int WidthPRDSBox = 128;
  localparam int WidthPRDWord = 64;
  localparam int WidthData    = 128;

  // Sp2V (sparse two-value) encoding used on the S-box handshake wires.
  typedef enum logic [2:0] {
    SP2V_HIGH = 3'b011,
    SP2V_LOW  = 3'b100
  } sp2v_e;

  // True only for the two legal Sp2V codes; anything else is a fault.
  function automatic logic sp2v_is_valid(input logic [2:0] v);
    return (v == SP2V_HIGH) || (v == SP2V_LOW);
  endfunction

endpackage

// File: rtl/aes_sub_bytes_ctrl_prd_collect.sv
// Assembles two 64-bit PRNG words into the 128-bit PRD for the S-boxes.
module aes_prd_collect
  import aes_sub_bytes_ctrl_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic                    ack_i,
  input  logic [WidthPRDWord-1:0] word_i,
  output logic                    done_o,
  output logic [WidthPRDSBox-1:0] prd_o
);

  logic                    cnt_q, cnt_d;
  logic [WidthPRDSBox-1:0] buf_q, buf_d;

  // Write the acknowledged word into the half selected by the word counter.
  always_comb begin
    cnt_d = cnt_q;
    buf_d = buf_q;
    if (req_i && ack_i) begin
      cnt_d = ~cnt_q;
      if (cnt_q) begin
        buf_d[WidthPRDSBox-1 -: WidthPRDWord] = word_i;
      end else begin
        buf_d[WidthPRDWord-1:0] = word_i;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and buffer state; reset discards any partially collected PRD.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 1'b0;
      buf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

  // The second acknowledged word completes the PRD.
  assign done_o = req_i & ack_i & cnt_q;
  assign prd_o  = buf_q;

endmodule

// File: rtl/aes_sub_bytes_ctrl.sv
// Sequencer in front of the masked SubBytes stage: captures the masked state,
// fetches PRD, drives the Sp2V S-box handshake and hands the result on.
module aes_sub_bytes_ctrl
  import aes_sub_bytes_ctrl_pkg::*;
#(
  parameter int unsigned SboxTimeout = 32,
  parameter bit          PrdRefresh  = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [WidthData-1:0]    in_data_i,
  input  logic [WidthData-1:0]    in_mask_i,
  output logic                    prd_req_o,
  input  logic                    prd_ack_i,
  input  logic [WidthPRDWord-1:0] prd_data_i,
  output logic [2:0]              sb_en_o,
  output logic                    sb_prd_we_o,
  input  logic [2:0]              sb_out_req_i,
  output logic [2:0]              sb_out_ack_o,
  output logic [WidthData-1:0]    sb_data_o,
  output logic [WidthData-1:0]    sb_mask_o,
  output logic [WidthPRDSBox-1:0] sb_prd_o,
  input  logic [WidthData-1:0]    sb_data_i,
  input  logic [WidthData-1:0]    sb_mask_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [WidthData-1:0]    out_data_o,
  output logic [WidthData-1:0]    out_mask_o,
  output logic                    err_o
);

  localparam logic [8:0] TmoLimit = 9'(SboxTimeout);

  // Pairwise Hamming distance of at least 3 so single upsets land in default.
  typedef enum logic [5:0] {
    ST_IDLE      = 6'b000000,
    ST_PRD_FETCH = 6'b000111,
    ST_PRD_LOAD  = 6'b011001,
    ST_SBOX      = 6'b101010,
    ST_OUT       = 6'b110100,
    ST_ERROR     = 6'b111111
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           tmo_q, tmo_d;
  logic [8:0]           tmo_inc;
  logic                 prd_loaded_q, prd_loaded_d;
  logic [WidthData-1:0] data_q, data_d, mask_q, mask_d;
  logic [WidthData-1:0] res_data_q, res_data_d, res_mask_q, res_mask_d;
  logic                 in_ready_q, in_ready_d;
  logic                 prd_req_q, prd_req_d;
  logic                 prd_we_q, prd_we_d;
  logic [2:0]           sb_en_q, sb_en_d;
  logic                 out_valid_q, out_valid_d;
  logic                 err_q, err_d;
  logic                 prd_done;

  aes_prd_collect u_prd_collect (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req_i  (prd_req_q),
    .ack_i  (prd_ack_i),
    .word_i (prd_data_i),
    .done_o (prd_done),
    .prd_o  (sb_prd_o)
  );

  // Next-state, operand capture, result capture and S-box stall watchdog.
  always_comb begin
    state_d      = state_q;
    tmo_d        = 8'd0;
    tmo_inc      = {1'b0, tmo_q} + 9'd1;
    prd_loaded_d = prd_loaded_q;
    data_d       = data_q;
    mask_d       = mask_q;
    res_data_d   = res_data_q;
    res_mask_d   = res_mask_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i && in_ready_q) begin
          data_d = in_data_i;
          mask_d = in_mask_i;
          if (PrdRefresh || !prd_loaded_q) begin
            state_d = ST_PRD_FETCH;
          end else begin
            state_d = ST_SBOX;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRD_FETCH: begin
        if (prd_done) begin
          state_d = ST_PRD_LOAD;
        end else begin
          state_d = ST_PRD_FETCH;
        end
      end
      ST_PRD_LOAD: begin
        prd_loaded_d = 1'b1;
        state_d      = ST_SBOX;
      end
      ST_SBOX: begin
        if (!sp2v_is_valid(sb_out_req_i)) begin
          state_d = ST_ERROR;
        end else if (sb_out_req_i == SP2V_HIGH) begin
          res_data_d = sb_data_i;
          res_mask_d = sb_mask_i;
          state_d    = ST_OUT;
        end else if (tmo_inc >= TmoLimit) begin
          state_d = ST_ERROR;
        end else begin
          tmo_d   = tmo_inc[7:0];
          state_d = ST_SBOX;
        end
      end
      ST_OUT: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_ERROR;
      end
    endcase
  end

  // Output values for the upcoming state, so every handshake output is a flop.
  always_comb begin
    in_ready_d  = 1'b0;
    prd_req_d   = 1'b0;
    prd_we_d    = 1'b0;
    sb_en_d     = SP2V_LOW;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    case (state_d)
      ST_IDLE:      in_ready_d  = 1'b1;
      ST_PRD_FETCH: prd_req_d   = 1'b1;
      ST_PRD_LOAD:  prd_we_d    = 1'b1;
      ST_SBOX:      sb_en_d     = SP2V_HIGH;
      ST_OUT:       out_valid_d = 1'b1;
      ST_ERROR:     err_d       = 1'b1;
      default:      err_d       = 1'b1;
    endcase
  end

  // All sequential state of the sequencer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      tmo_q        <= 8'd0;
      prd_loaded_q <= 1'b0;
      data_q       <= '0;
      mask_q       <= '0;
      res_data_q   <= '0;
      res_mask_q   <= '0;
      in_ready_q   <= 1'b1;
      prd_req_q    <= 1'b0;
      prd_we_q     <= 1'b0;
      sb_en_q      <= SP2V_LOW;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      prd_loaded_q <= prd_loaded_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      res_data_q   <= res_data_d;
      res_mask_q   <= res_mask_d;
      in_ready_q   <= in_ready_d;
      prd_req_q    <= prd_req_d;
      prd_we_q     <= prd_we_d;
      sb_en_q      <= sb_en_d;
      out_valid_q  <= out_valid_d;
      err_q        <= err_d;
    end
  end

  // The acknowledge must answer the request in the same cycle.
  always_comb begin
    if ((state_q == ST_SBOX) && (sb_out_req_i == SP2V_HIGH)) begin
      sb_out_ack_o = SP2V_HIGH;
    end else begin
      sb_out_ack_o = SP2V_LOW;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign prd_req_o   = prd_req_q;
  assign sb_prd_we_o = prd_we_q;
  assign sb_en_o     = sb_en_q;
  assign sb_data_o   = data_q;
  assign sb_mask_o   = mask_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = res_data_q;
  assign out_mask_o  = res_mask_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_aes_sub_bytes_ctrl.sv
// Scoreboard bench for aes_sub_bytes_ctrl: randomized operations, directed
// error/timeout/reset cases, and a second instance without PRD refresh.
module tb_aes_sub_bytes_ctrl;
  import aes_sub_bytes_ctrl_pkg::*;

  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst;
  logic in_valid, in_ready, prd_req, prd_ack, sb_prd_we, out_valid, out_ready, err;
  logic [127:0] in_data, in_mask, sb_data_o, sb_mask_o, sb_prd_o, sb_data_i, sb_mask_i, out_data, out_mask;
  logic [63:0]  prd_data;
  logic [2:0]   sb_en, sb_out_req, sb_out_ack;

  aes_sub_bytes_ctrl #(.SboxTimeout(TMO), .PrdRefresh(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_mask_i(in_mask), .prd_req_o(prd_req), .prd_ack_i(prd_ack),
    .prd_data_i(prd_data), .sb_en_o(sb_en), .sb_prd_we_o(sb_prd_we), .sb_out_req_i(sb_out_req),
    .sb_out_ack_o(sb_out_ack), .sb_data_o(sb_data_o), .sb_mask_o(sb_mask_o), .sb_prd_o(sb_prd_o),
    .sb_data_i(sb_data_i), .sb_mask_i(sb_mask_i), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_mask_o(out_mask), .err_o(err));

  logic n_in_valid, n_in_ready, n_prd_req, n_prd_ack, n_sb_prd_we, n_out_valid, n_out_ready, n_err;
  logic [127:0] n_in_data, n_in_mask, n_sb_data_o, n_sb_mask_o, n_sb_prd_o, n_sb_data_i, n_sb_mask_i, n_out_data, n_out_mask;
  logic [63:0]  n_prd_data;
  logic [2:0]   n_sb_en, n_sb_out_req, n_sb_out_ack;

  aes_sub_bytes_ctrl #(.SboxTimeout(32), .PrdRefresh(1'b0)) dut_nr (
    .clk_i(clk), .rst_i(rst), .in_valid_i(n_in_valid), .in_ready_o(n_in_ready),
    .in_data_i(n_in_data), .in_mask_i(n_in_mask), .prd_req_o(n_prd_req), .prd_ack_i(n_prd_ack),
    .prd_data_i(n_prd_data), .sb_en_o(n_sb_en), .sb_prd_we_o(n_sb_prd_we), .sb_out_req_i(n_sb_out_req),
    .sb_out_ack_o(n_sb_out_ack), .sb_data_o(n_sb_data_o), .sb_mask_o(n_sb_mask_o), .sb_prd_o(n_sb_prd_o),
    .sb_data_i(n_sb_data_i), .sb_mask_i(n_sb_mask_i), .out_valid_o(n_out_valid), .out_ready_i(n_out_ready),
    .out_data_o(n_out_data), .out_mask_o(n_out_mask), .err_o(n_err));

  typedef struct packed { logic [127:0] d; logic [127:0] m; } exp_t;
  exp_t         sb_q[$];
  logic [63:0]  prd_q[$];
  logic [127:0] prdexp_q[$];

  int checks = 0, failures = 0;
  int ack_pct = 100, sbox_mode = 0, sbox_delay = 3, stall_cycles = 0;
  int acc_cyc = 0, we_cyc = 0, en_cyc = 0, req_cyc = 0, ill_cyc = 0, we_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // PRNG model: acknowledges requests (with random gaps) from a word queue.
  initial begin
    prd_ack = 1'b0; prd_data = 64'd0;
    forever begin
      @(negedge clk);
      if (!rst && prd_req && (prd_q.size() > 0) && ($urandom_range(0, 99) < ack_pct)) begin
        prd_ack = 1'b1; prd_data = prd_q.pop_front();
      end else begin
        prd_ack = 1'b0; prd_data = rnd64();
      end
    end
  end

  // S-box model: answers an enable with a result derived from its operands.
  initial begin
    int cnt = 0, dly = 0;
    sb_out_req = SP2V_LOW; sb_data_i = 128'd0; sb_mask_i = 128'd0;
    forever begin
      @(negedge clk);
      if (sb_en == SP2V_HIGH) begin
        if (cnt == 0) begin
          en_cyc = cyc;
          dly = (sbox_delay >= 0) ? sbox_delay : int'($urandom_range(0, 4));
        end
        if (sbox_mode == 1 && cnt == 2) begin
          sb_out_req = 3'b001; ill_cyc = cyc;
        end else if (sbox_mode == 0 && cnt == dly) begin
          sb_out_req = SP2V_HIGH; req_cyc = cyc;
          sb_data_i = sb_data_o ^ sb_prd_o; sb_mask_i = ~sb_mask_o;
          #1 chk("sb_out_ack_high", 128'(sb_out_ack), 128'(3'b011));
        end else begin
          sb_out_req = SP2V_LOW; sb_data_i = rnd128(); sb_mask_i = rnd128();
          #1 chk("sb_out_ack_low", 128'(sb_out_ack), 128'(3'b100));
        end
        cnt++;
      end else begin
        sb_out_req = SP2V_LOW; cnt = 0;
      end
    end
  end

  // PRD load monitor: each load strobe must carry the next expected PRD.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && sb_prd_we) begin
        we_cyc = cyc; we_cnt++;
        if (prdexp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL prd_load_unexpected actual=strobe required=none");
        end else begin
          chk("sb_prd_at_load", sb_prd_o, prdexp_q.pop_front());
        end
      end
    end
  end

  // Output monitor: pops the scoreboard, applies back-pressure, checks stability.
  initial begin
    bit holding = 1'b0, hs = 1'b0;
    int stall = 0;
    logic [127:0] hd = 128'd0, hm = 128'd0;
    exp_t e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        holding = 1'b0; hs = 1'b0; out_ready = 1'b0;
      end else begin
        if (hs) begin
          hs = 1'b0;
          chk("idle_after_handshake", 128'({in_ready, out_valid}), 128'(2'b10));
        end
        if (out_valid) begin
          if (!holding) begin
            holding = 1'b1; hd = out_data; hm = out_mask;
            chk("out_latency", 128'(cyc), 128'(req_cyc + 1));
            if (sb_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL output_unexpected actual=valid required=none");
            end else begin
              e = sb_q.pop_front();
              chk("out_data", out_data, e.d);
              chk("out_mask", out_mask, e.m);
            end
            stall = (stall_cycles > 0) ? stall_cycles : int'($urandom_range(0, 2));
          end else begin
            chk("out_data_stable", out_data, hd);
            chk("out_mask_stable", out_mask, hm);
          end
          if (stall == 0) begin
            out_ready = 1'b1; holding = 1'b0; hs = 1'b1;
          end else begin
            out_ready = 1'b0; stall--;
          end
        end else begin
          out_ready = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [127:0] d, input logic [127:0] m,
                       input logic [63:0] w0, input logic [63:0] w1, input bit push_sb);
    bit ok = 1'b0;
    prd_q.push_back(w0); prd_q.push_back(w1);
    prdexp_q.push_back({w1, w0});
    if (push_sb) sb_q.push_back('{d: d ^ {w1, w0}, m: ~m});
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_mask = m;
    for (int t = 0; t < 300 && !ok; t++) begin
      #1;
      if (in_ready) begin ok = 1'b1; acc_cyc = cyc; end
      @(negedge clk);
    end
    in_valid = 1'b0; in_data = rnd128();
    chk("input_accepted", 128'(ok), 128'd1);
  endtask

  task automatic drain(input string tag);
    bit ok = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk); #2;
      if (sb_q.size() == 0 && prd_q.size() == 0 && in_ready && !out_valid) ok = 1'b1;
    end
    chk({tag, "_drained"}, 128'(ok), 128'd1);
  endtask

  task automatic wait_err(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (err) ok = 1'b1;
    end
    chk("err_raised", 128'(ok), 128'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    prd_q.delete(); prdexp_q.delete(); sb_q.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ctrl"}, 128'({in_ready, prd_req, sb_prd_we, out_valid, err, sb_en, sb_out_ack}),
        128'(11'b10000100100));
    chk({tag, "_sb_data"}, sb_data_o, 128'd0);
    chk({tag, "_sb_mask"}, sb_mask_o, 128'd0);
    chk({tag, "_sb_prd"}, sb_prd_o, 128'd0);
    chk({tag, "_out_data"}, out_data, 128'd0);
    chk({tag, "_out_mask"}, out_mask, 128'd0);
  endtask

  task automatic nr_op(input logic [127:0] d, input logic [127:0] m, input logic [63:0] w0,
                       input logic [63:0] w1, output int req_cycles, output int sbox_lat,
                       output logic [127:0] got_d, output logic [127:0] got_m);
    int acks = 0, acc = -1, first_sb = -1;
    bit done = 1'b0;
    req_cycles = 0; got_d = 128'd0; got_m = 128'd0;
    @(negedge clk);
    n_in_valid = 1'b1; n_in_data = d; n_in_mask = m;
    for (int t = 0; t < 50 && acc < 0; t++) begin
      #1;
      if (n_in_ready) acc = cyc;
      @(negedge clk);
    end
    n_in_valid = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      n_out_ready = 1'b0;
      if (n_prd_req) begin
        req_cycles++; n_prd_ack = 1'b1; n_prd_data = (acks == 0) ? w0 : w1; acks++;
      end else begin
        n_prd_ack = 1'b0;
      end
      if (n_sb_en == SP2V_HIGH) begin
        if (first_sb < 0) first_sb = cyc;
        n_sb_out_req = SP2V_HIGH; n_sb_data_i = n_sb_data_o ^ n_sb_prd_o; n_sb_mask_i = ~n_sb_mask_o;
      end else begin
        n_sb_out_req = SP2V_LOW;
      end
      if (n_out_valid) begin
        got_d = n_out_data; got_m = n_out_mask; n_out_ready = 1'b1; done = 1'b1;
      end
      @(negedge clk);
    end
    n_out_ready = 1'b0; n_prd_ack = 1'b0; n_sb_out_req = SP2V_LOW;
    sbox_lat = first_sb - acc;
    chk("nr_op_completed", 128'({acc >= 0, done}), 128'(2'b11));
  endtask

  initial begin
    logic [127:0] d, m, gd, gm;
    logic [63:0]  w0, w1;
    int rc, lat;
    bit ok;
    rst = 1'b1; in_valid = 1'b0; in_data = 128'd0; in_mask = 128'd0;
    n_in_valid = 1'b0; n_in_data = 128'd0; n_in_mask = 128'd0; n_prd_ack = 1'b0;
    n_prd_data = 64'd0; n_sb_out_req = SP2V_LOW; n_sb_data_i = 128'd0; n_sb_mask_i = 128'd0;
    n_out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // Nominal operation with fixed PRD words, 3-cycle S-box and 5-cycle stall.
    ack_pct = 100; sbox_delay = 3; stall_cycles = 5; we_cnt = 0;
    issue(128'h00112233445566778899AABBCCDDEEFF, rnd128(),
          64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A, 1'b1);
    drain("nominal");
    chk("nominal_load_cycle", 128'(we_cyc), 128'(acc_cyc + 3));
    chk("nominal_sbox_cycle", 128'(en_cyc), 128'(acc_cyc + 4));
    chk("nominal_we_pulses", 128'(we_cnt), 128'd1);
    chk("nominal_sb_prd", sb_prd_o, {64'h5A5A5A5A5A5A5A5A, 64'hA5A5A5A5A5A5A5A5});

    // Randomized operations with PRD gaps, random S-box delay and stalls.
    ack_pct = 60; sbox_delay = -1; stall_cycles = 0;
    for (int i = 0; i < 20; i++) issue(rnd128(), rnd128(), rnd64(), rnd64(), 1'b1);
    drain("random");

    // Illegal Sp2V request while in SBOX.
    ack_pct = 100; sbox_mode = 1;
    issue(rnd128(), rnd128(), rnd64(), rnd64(), 1'b0);
    wait_err(ok);
    chk("illegal_err_cycle", 128'(cyc), 128'(ill_cyc + 1));
    chk("illegal_outputs", 128'({in_ready, prd_req, sb_prd_we, out_valid, err, sb_en, sb_out_ack}),
        128'(11'b00001100100));
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("error_sticky", 128'({in_ready, err}), 128'(2'b01));
    end
    in_valid = 1'b0;
    sbox_mode = 0;
    do_reset();

    // S-box never answers: error exactly TMO cycles after SBOX entry.
    sbox_mode = 2;
    issue(rnd128(), rnd128(), rnd64(), rnd64(), 1'b0);
    wait_err(ok);
    chk("timeout_cycles", 128'(cyc - en_cyc), 128'(TMO));
    sbox_mode = 0;
    do_reset();

    // Reset after the first PRD word, then a fresh full operation.
    issue(rnd128(), rnd128(), rnd64(), rnd64(), 1'b1);
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(posedge clk);
      if (prd_ack) ok = 1'b1;
    end
    chk("first_prd_ack_seen", 128'(ok), 128'd1);
    @(negedge clk);
    rst = 1'b1;
    #1 check_reset_vals("midop_reset");
    prd_q.delete(); prdexp_q.delete(); sb_q.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    issue(rnd128(), rnd128(), rnd64(), rnd64(), 1'b1);
    drain("after_reset");

    // Instance without PRD refresh: only the first operation fetches PRD.
    d = rnd128(); m = rnd128(); w0 = rnd64(); w1 = rnd64();
    nr_op(d, m, w0, w1, rc, lat, gd, gm);
    chk("nr1_prd_req_cycles", 128'(rc), 128'd2);
    chk("nr1_sbox_latency", 128'(lat), 128'd4);
    chk("nr1_out_data", gd, d ^ {w1, w0});
    chk("nr1_out_mask", gm, ~m);
    d = rnd128(); m = rnd128();
    nr_op(d, m, rnd64(), rnd64(), rc, lat, gd, gm);
    chk("nr2_prd_req_cycles", 128'(rc), 128'd0);
    chk("nr2_sbox_latency", 128'(lat), 128'd1);
    chk("nr2_out_data", gd, d ^ {w1, w0});
    chk("nr2_out_mask", gm, ~m);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_sub_bytes_ctrl.md
# aes_sub_bytes_ctrl

Sequencer directly upstream of the masked SubBytes stage. Accepts one masked 128-bit state from the cipher core, fetches fresh 128-bit pseudo-random data (PRD) from the PRNG in two 64-bit words, loads it into the S-boxes, and drives the S-boxes' Sp2V-encoded enable and acknowledge. It then captures the masked result and hands it downstream. It also detects invalid Sp2V encodings and S-box stalls and reports them as a sticky fatal error.

## Interface
- SboxTimeout, default 32: maximum cycles in SBOX before a timeout error (legal range 4..255).
- PrdRefresh, default 1'b1: 1 = fetch new PRD for every operation; 0 = fetch only for the first operation after reset.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  masked state valid.
- in_ready_o  out  1  ready for a new state.
- in_data_i  in  128  masked data.
- in_mask_i  in  128  mask.
- prd_req_o  out  1  request one 64-bit PRD word.
- prd_ack_i  in  1  PRD word valid this cycle.
- prd_data_i  in  64  PRD word.
- sb_en_o  out  3  Sp2V S-box enable.
- sb_prd_we_o  out  1  PRD load strobe.
- sb_out_req_i  in  3  Sp2V S-box result request.
- sb_out_ack_o  out  3  Sp2V S-box result acknowledge.
- sb_data_o / sb_mask_o / sb_prd_o  out  128 each  operands to the S-boxes.
- sb_data_i / sb_mask_i  in  128 each  S-box results.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream ready.
- out_data_o / out_mask_o  out  128 each  result.
- err_o  out  1  sticky fatal error.

## Operation
- Sp2V encodings: HIGH = 3'b011, LOW = 3'b100. Any other value on sb_out_req_i while in SBOX is an error.
- FSM states: IDLE, PRD_FETCH, PRD_LOAD, SBOX, OUT, ERROR.
- IDLE:
  - in_ready_o = 1.
  - On in_valid_i & in_ready_o, capture data and mask.
  - Go to PRD_FETCH if (PrdRefresh or no PRD loaded since reset); otherwise go to SBOX.
- PRD_FETCH:
  - prd_req_o = 1.
  - Each cycle with prd_ack_i = 1 writes prd_data_i into prd_buf[cnt*64 +: 64], where cnt is a 1-bit word counter starting at 0.
  - The second ack moves the FSM to PRD_LOAD and clears cnt.
  - prd_ack_i outside PRD_FETCH is ignored.
- PRD_LOAD: sb_prd_we_o = 1 for exactly one cycle, then SBOX. The prd_loaded flag is set.
- SBOX:
  - sb_en_o = HIGH; a timeout counter clears on entry and increments each cycle.
  - When sb_out_req_i == HIGH: sb_out_ack_o = HIGH in the same cycle (combinational), capture sb_data_i and sb_mask_i, then go to OUT.
  - Counter reaching SboxTimeout → ERROR.
- OUT: out_valid_o = 1 with the captured result held stable until out_ready_i, then IDLE.
- ERROR:
  - Terminal until reset; err_o = 1.
  - All valid/ready/req/we outputs are 0; sb_en_o and sb_out_ack_o are LOW.
  - An illegal FSM encoding also enters ERROR.
- sb_data_o, sb_mask_o and sb_prd_o are register outputs held constant from capture until the next accepted input.
- In every state other than SBOX (or the ack cycle), sb_en_o and sb_out_ack_o are LOW.

## Timing
- Reset values:
  - FSM = IDLE; err_o = 0; prd_loaded = 0; cnt = 0.
  - in_ready_o = 1.
  - prd_req_o, sb_prd_we_o and out_valid_o = 0.
  - sb_en_o and sb_out_ack_o = LOW.
  - All data registers = 0.
- Minimum latency with PrdRefresh and back-to-back acks: accept at cycle 0; PRD_FETCH cycles 1–2; PRD_LOAD cycle 3; SBOX from cycle 4; out_valid_o one cycle after the S-box request.
- With PRD skipped: SBOX starts the cycle after accept.
- PRD_FETCH may take any number of cycles; gaps in prd_ack_i are allowed.
- Reset asserted mid-operation: immediate return to reset values. Partial PRD is discarded and prd_loaded is cleared.
- In OUT, out_valid_o must not drop until out_ready_i. A new input is accepted no earlier than the cycle after the output handshake.
- The timeout check uses ≥, so the error is raised exactly SboxTimeout cycles after SBOX entry if no request arrives.

## Structure
- Shared aes_pkg constants: SP2V_HIGH and SP2V_LOW, the sp2v_e typedef, and WidthPRDSBox.
- FSM state enum local to the module, sparse-encoded (Hamming distance ≥ 3).
- One natural sub-module: aes_prd_collect. It contains the word counter and the 128-bit buffer, with the interface req/ack/word in and done/prd out.

## Test plan
- Nominal, PrdRefresh = 1:
  - Stimulus: in_data_i = 0x00112233…, PRD words 0xA5A5… and 0x5A5A… on consecutive acks; S-box requests HIGH 3 cycles after SBOX entry.
  - Required response: sb_prd_o = {0x5A5A…, 0xA5A5…}; one sb_prd_we_o pulse; out_valid_o at the expected cycle; result equals the S-box data.
- PrdRefresh = 0, two operations:
  - Required response: prd_req_o asserts only during the first operation; the second goes from IDLE straight to SBOX.
- sb_out_req_i = 3'b001 during SBOX:
  - Required response: err_o = 1 next cycle; sb_en_o = 3'b100; in_ready_o stays 0 until rst_i.
- No S-box request with SboxTimeout = 8:
  - Required response: err_o rises exactly 8 cycles after SBOX entry.
- out_ready_i held low for 5 cycles:
  - Required response: out_valid_o and out_data_o stay stable; return to IDLE one cycle after ready.
- rst_i pulsed after the first PRD ack:
  - Required response: all outputs return to reset values; the next operation fetches two fresh words.
